// File: rtl/i2c_xfer_sched.sv
// Round-robin scheduler sharing one byte-level I2C engine between a command
// requester (0) and an LCD data requester (1), with bounded retry on NACK.
module i2c_xfer_sched #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h27,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              ck,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] base0,
  input  logic [ADDR_W-1:0] base1,
  input  logic [7:0]        len0,
  input  logic [7:0]        len1,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic [1:0]        err,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_sel,
  input  logic [7:0]        rom_data,
  output logic              eng_go,
  output logic [1:0]        eng_cmd,
  output logic [7:0]        eng_wdata,
  input  logic              eng_busy,
  input  logic              eng_done,
  input  logic              eng_nack
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_START, S_ADDR, S_FETCH, S_DATA, S_STOP, S_FIN
  } state_t;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_STOP  = 2'b10
  } cmd_t;

  state_t              state;
  logic                id;
  logic                last;
  logic                fail;
  logic                pend;
  logic [RETRY_W-1:0]  retry;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   base_l;
  logic [7:0]          cnt;
  logic [7:0]          len_l;
  logic                win;
  logic                can_issue;
  logic                cmd_done;

  assign rom_addr = ptr;
  assign rom_sel  = id;
  assign win      = (req == 2'b11) ? ~last : req[1];
  // A completion is only accepted once the strobe has dropped and a command is outstanding.
  assign can_issue = !pend && !eng_go && !eng_busy;
  assign cmd_done  = pend && !eng_go && eng_done;

  always_ff @(posedge ck) begin
    if (reset) begin
      state     <= S_IDLE;
      grant     <= '0;
      done      <= '0;
      err       <= '0;
      eng_go    <= 1'b0;
      eng_cmd   <= CMD_STOP;
      eng_wdata <= '0;
      id        <= 1'b0;
      last      <= 1'b1;
      fail      <= 1'b0;
      pend      <= 1'b0;
      retry     <= '0;
      ptr       <= '0;
      base_l    <= '0;
      cnt       <= '0;
      len_l     <= '0;
    end else begin
      eng_go <= 1'b0;
      done   <= '0;
      err    <= '0;
      case (state)
        // The requester just finished is still seeing its pulse; do not re-grant it on that.
        S_IDLE: if ((req & ~(done | err)) != '0) state <= S_ARB;
        S_ARB: begin
          if (req == 2'b00) begin
            state <= S_IDLE;
          end else begin
            id     <= win;
            grant  <= win ? 2'b10 : 2'b01;
            base_l <= win ? base1 : base0;
            len_l  <= win ? len1 : len0;
            ptr    <= win ? base1 : base0;
            cnt    <= win ? len1 : len0;
            retry  <= '0;
            fail   <= 1'b0;
            state  <= S_START;
          end
        end
        S_START: begin
          if (can_issue) begin
            eng_go  <= 1'b1;
            eng_cmd <= CMD_START;
            pend    <= 1'b1;
          end else if (cmd_done) begin
            pend  <= 1'b0;
            state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (can_issue) begin
            eng_go    <= 1'b1;
            eng_cmd   <= CMD_WRITE;
            eng_wdata <= {SLAVE_ADDR, 1'b0};
            pend      <= 1'b1;
          end else if (cmd_done) begin
            pend <= 1'b0;
            if (eng_nack) begin
              fail  <= 1'b1;
              state <= S_STOP;
            end else begin
              state <= (cnt != 8'd0) ? S_FETCH : S_STOP;
            end
          end
        end
        S_FETCH: begin
          eng_wdata <= rom_data;
          state     <= S_DATA;
        end
        S_DATA: begin
          if (can_issue) begin
            eng_go  <= 1'b1;
            eng_cmd <= CMD_WRITE;
            pend    <= 1'b1;
          end else if (cmd_done) begin
            pend <= 1'b0;
            if (eng_nack) begin
              fail  <= 1'b1;
              state <= S_STOP;
            end else begin
              ptr   <= ptr + 1'b1;
              cnt   <= cnt - 8'd1;
              state <= (cnt != 8'd1) ? S_FETCH : S_STOP;
            end
          end
        end
        S_STOP: begin
          if (can_issue) begin
            eng_go  <= 1'b1;
            eng_cmd <= CMD_STOP;
            pend    <= 1'b1;
          end else if (cmd_done) begin
            pend <= 1'b0;
            if (fail && (retry < RETRY_LIM)) begin
              retry <= retry + 1'b1;
              ptr   <= base_l;
              cnt   <= len_l;
              fail  <= 1'b0;
              state <= S_START;
            end else begin
              state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          if (fail) err  <= id ? 2'b10 : 2'b01;
          else      done <= id ? 2'b10 : 2'b01;
          last  <= id;
          grant <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
